// File: rtl/combo_solver_dispatcher_pkg.sv
// Shared definitions for the combo solver dispatcher: FSM state encoding and
// the width of a per-core press-count result.
package combo_solver_dispatcher_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    function automatic int presses_width(input int max_buttons);
        return $clog2(max_buttons + 1);
    endfunction

endpackage

// File: rtl/combo_solver_dispatcher_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from the pointer upward; the
// pointer moves to just past the granted requester only when advance is set.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);

    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;
    logic             found;
    int               idx;

    always_comb begin
        grant = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr_q) + k) % N;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                ptr_d      = PTR_W'((idx + 1) % N);
            end
        end
        if (!advance) begin
            ptr_d = ptr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/combo_solver_dispatcher.sv
// Dispatches machine descriptors to idle solver cores and sums their results.
// Optional statistics outputs are enabled by defining COMBO_DISPATCH_STATS_EN.
module combo_solver_dispatcher
    import combo_solver_dispatcher_pkg::*;
#(
    parameter int NUM_CORES        = 4,
    parameter int MAX_LIGHT_COUNT  = 2,
    parameter int MAX_BUTTON_COUNT = 10,
    parameter int SUM_WIDTH        = 16
) (
    input  logic                                                  clk,
    input  logic                                                  reset,
    input  logic                                                  in_valid,
    input  logic [MAX_LIGHT_COUNT*MAX_BUTTON_COUNT-1:0]           in_buttons,
    input  logic [MAX_LIGHT_COUNT-1:0]                            in_lights,
    input  logic                                                  in_last,
    output logic                                                  in_ready,
    output logic [MAX_LIGHT_COUNT*MAX_BUTTON_COUNT-1:0]           core_buttons,
    output logic [MAX_LIGHT_COUNT-1:0]                            core_lights,
    output logic [NUM_CORES-1:0]                                  core_tx_valid,
    input  logic [NUM_CORES-1:0]                                  core_ready,
    input  logic [NUM_CORES*presses_width(MAX_BUTTON_COUNT)-1:0]  core_presses,
    input  logic [NUM_CORES-1:0]                                  core_presses_valid,
    output logic [NUM_CORES-1:0]                                  core_rx_ready,
    output logic [SUM_WIDTH-1:0]                                  total_presses,
    output logic                                                  total_overflow,
    output logic                                                  total_valid,
    input  logic                                                  total_ack
`ifdef COMBO_DISPATCH_STATS_EN
    ,
    output logic [SUM_WIDTH-1:0]                                  stat_machines,
    output logic [SUM_WIDTH-1:0]                                  stat_unsolved
`endif
);

    localparam int PW = presses_width(MAX_BUTTON_COUNT);
    localparam int OW = $clog2(NUM_CORES + 1);
    localparam int AW = ((SUM_WIDTH > PW) ? SUM_WIDTH : PW) + 1;

    // Returns {saturated, sum}; the sum clamps at the all-ones value.
    function automatic logic [SUM_WIDTH:0] sat_add(input logic [SUM_WIDTH-1:0] a,
                                                   input logic [PW-1:0]        b);
        logic [AW-1:0] s;
        s = AW'(a) + AW'(b);
        if (s > AW'({SUM_WIDTH{1'b1}})) begin
            return {1'b1, {SUM_WIDTH{1'b1}}};
        end
        return {1'b0, s[SUM_WIDTH-1:0]};
    endfunction

    state_e                 state_q, state_d;
    logic [NUM_CORES-1:0]   busy_q, busy_d;
    logic [OW-1:0]          outst_q, outst_d;
    logic [SUM_WIDTH-1:0]   sum_q, sum_d;
    logic                   ovf_q, ovf_d;
    logic [SUM_WIDTH:0]     add_res;

    logic [NUM_CORES-1:0]   free;
    logic [NUM_CORES-1:0]   disp_grant;
    logic [NUM_CORES-1:0]   coll_grant;
    logic                   accept;
    logic                   collect;
    logic                   coll_live;
    logic                   start_run;
    logic [PW-1:0]          coll_presses;

    assign core_buttons = in_buttons;
    assign core_lights  = in_lights;

    assign free          = core_ready & ~core_presses_valid & ~busy_q;
    assign in_ready      = (state_q == ST_RUN) && (|free);
    assign accept        = in_valid && in_ready;
    assign core_tx_valid = accept ? disp_grant : '0;

    // Results are only taken while a run is active; stale results from an
    // abandoned run are drained then but never summed (busy bit is clear).
    assign collect       = ((state_q == ST_RUN) || (state_q == ST_DRAIN)) && (|core_presses_valid);
    assign core_rx_ready = collect ? coll_grant : '0;
    assign coll_live     = |(core_rx_ready & busy_q);
    assign start_run     = (state_q == ST_IDLE) && in_valid;

    assign total_presses  = sum_q;
    assign total_overflow = ovf_q;
    assign total_valid    = (state_q == ST_DONE);

    rr_arbiter #(.N(NUM_CORES)) u_disp_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (free),
        .advance (accept),
        .grant   (disp_grant)
    );

    rr_arbiter #(.N(NUM_CORES)) u_coll_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (core_presses_valid),
        .advance (collect),
        .grant   (coll_grant)
    );

    always_comb begin
        coll_presses = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (coll_grant[i]) begin
                coll_presses = coll_presses | core_presses[i*PW +: PW];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        outst_d = outst_q;
        sum_d   = sum_q;
        ovf_d   = ovf_q;
        add_res = sat_add(sum_q, coll_presses);

        case (state_q)
            ST_IDLE:  if (in_valid) state_d = ST_RUN;
            ST_RUN:   if (accept && in_last) state_d = ST_DRAIN;
            ST_DRAIN: if ((outst_q == '0) && !collect) state_d = ST_DONE;
            ST_DONE:  if (total_ack) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        if (accept) begin
            busy_d = busy_d | core_tx_valid;
        end
        if (coll_live) begin
            busy_d = busy_d & ~core_rx_ready;
            sum_d  = add_res[SUM_WIDTH-1:0];
            ovf_d  = ovf_q | add_res[SUM_WIDTH];
        end

        case ({accept, coll_live})
            2'b10:   outst_d = outst_q + OW'(1);
            2'b01:   outst_d = outst_q - OW'(1);
            default: outst_d = outst_q;
        endcase

        if (start_run) begin
            sum_d = '0;
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            busy_q  <= '0;
            outst_q <= '0;
            sum_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            outst_q <= outst_d;
            sum_q   <= sum_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef COMBO_DISPATCH_STATS_EN
    function automatic logic [SUM_WIDTH-1:0] sat_inc(input logic [SUM_WIDTH-1:0] v);
        return (&v) ? v : v + SUM_WIDTH'(1);
    endfunction

    logic [SUM_WIDTH-1:0] stm_q, stm_d;
    logic [SUM_WIDTH-1:0] stu_q, stu_d;

    always_comb begin
        stm_d = stm_q;
        stu_d = stu_q;
        if (coll_live) begin
            stm_d = sat_inc(stm_q);
            if (coll_presses == PW'(MAX_BUTTON_COUNT)) begin
                stu_d = sat_inc(stu_q);
            end
        end
        if (start_run) begin
            stm_d = '0;
            stu_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stm_q <= '0;
            stu_q <= '0;
        end else begin
            stm_q <= stm_d;
            stu_q <= stu_d;
        end
    end

    assign stat_machines = stm_q;
    assign stat_unsolved = stu_q;
`endif

endmodule

// File: tb/tb_combo_solver_dispatcher.sv
// Bench for combo_solver_dispatcher: behavioural solver cores, directed
// scenarios and randomized runs checked against a sum-and-saturate model.
module tb_combo_solver_dispatcher;

    localparam int NC = 4;
    localparam int LC = 2;
    localparam int BC = 10;
    localparam int SW = 4;
    localparam int PW = 4;
    localparam int BW = LC * BC;
    localparam int SMAX = (1 << SW) - 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic             in_valid = 1'b0;
    logic [BW-1:0]    in_buttons = '0;
    logic [LC-1:0]    in_lights = '0;
    logic             in_last = 1'b0;
    logic             in_ready;
    logic [BW-1:0]    core_buttons;
    logic [LC-1:0]    core_lights;
    logic [NC-1:0]    core_tx_valid;
    logic [NC-1:0]    core_ready;
    logic [NC*PW-1:0] core_presses;
    logic [NC-1:0]    core_presses_valid;
    logic [NC-1:0]    core_rx_ready;
    logic [SW-1:0]    total_presses;
    logic             total_overflow;
    logic             total_valid;
    logic             total_ack = 1'b0;
`ifdef COMBO_DISPATCH_STATS_EN
    logic [SW-1:0]    stat_machines;
    logic [SW-1:0]    stat_unsolved;
`endif

    combo_solver_dispatcher #(
        .NUM_CORES(NC), .MAX_LIGHT_COUNT(LC), .MAX_BUTTON_COUNT(BC), .SUM_WIDTH(SW)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_buttons(in_buttons), .in_lights(in_lights),
        .in_last(in_last), .in_ready(in_ready),
        .core_buttons(core_buttons), .core_lights(core_lights),
        .core_tx_valid(core_tx_valid), .core_ready(core_ready),
        .core_presses(core_presses), .core_presses_valid(core_presses_valid),
        .core_rx_ready(core_rx_ready),
        .total_presses(total_presses), .total_overflow(total_overflow),
        .total_valid(total_valid), .total_ack(total_ack)
`ifdef COMBO_DISPATCH_STATS_EN
        , .stat_machines(stat_machines), .stat_unsolved(stat_unsolved)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Behavioural solver cores: fixed answer after a per-dispatch latency.
    logic [NC-1:0] en_m = '1;
    logic [NC-1:0] busy_m = '0;
    logic [NC-1:0] vld_m = '0;
    int            cnt_m [NC];
    int            ans_m [NC];
    logic [NC-1:0] tx_s = '0;
    logic [NC-1:0] rx_s = '0;
    int            ans_cur = 0, lat_cur = 1, ans_s = 0, lat_s = 1;
    int            cyc = 0;
    int            disp_q[$];
    int            coll_core_q[$];
    int            coll_cyc_q[$];
    int            run_ans[$];
    int            run_lat[$];
    int            stall_q[$];

    assign core_ready         = en_m & ~busy_m;
    assign core_presses_valid = vld_m;

    always_comb begin
        core_presses = '0;
        for (int i = 0; i < NC; i++) begin
            if (vld_m[i]) core_presses[i*PW +: PW] = PW'(ans_m[i]);
        end
    end

    always @(negedge clk) begin
        tx_s  = core_tx_valid;
        rx_s  = core_rx_ready;
        ans_s = ans_cur;
        lat_s = lat_cur;
        for (int i = 0; i < NC; i++) begin
            if (tx_s[i]) disp_q.push_back(i);
            if (rx_s[i] && vld_m[i]) begin
                coll_core_q.push_back(i);
                coll_cyc_q.push_back(cyc);
            end
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < NC; i++) begin
            if (tx_s[i]) begin
                busy_m[i] <= 1'b1;
                cnt_m[i]  <= lat_s;
                ans_m[i]  <= ans_s;
            end else if (busy_m[i] && !vld_m[i]) begin
                if (cnt_m[i] <= 1) vld_m[i] <= 1'b1;
                else               cnt_m[i] <= cnt_m[i] - 1;
            end
            if (rx_s[i] && vld_m[i]) begin
                vld_m[i]  <= 1'b0;
                busy_m[i] <= 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        total_ack = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
    endtask

    task automatic send(input int ans, input int lat, input bit last, output int stall);
        stall      = 0;
        in_valid   = 1'b1;
        in_last    = last;
        in_buttons = BW'($urandom);
        in_lights  = LC'($urandom);
        ans_cur    = ans;
        lat_cur    = lat;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (in_ready) begin
                check("bcast_buttons", core_buttons, in_buttons);
                check("bcast_lights", core_lights, in_lights);
                tick();
                in_valid = 1'b0;
                in_last  = 1'b0;
                return;
            end
            tick();
            stall++;
        end
        check("accept_timeout", in_ready, 1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic finish_run(input string tag, input int exp_total, input int exp_ovf,
                              input int exp_m, input int exp_u, input int hold);
        for (int t = 0; t < 600; t++) begin
            @(negedge clk);
            if (total_valid) break;
        end
        check({tag, "_done"}, total_valid, 1);
        check({tag, "_total"}, total_presses, exp_total);
        check({tag, "_ovf"}, total_overflow, exp_ovf);
`ifdef COMBO_DISPATCH_STATS_EN
        check({tag, "_stat_m"}, stat_machines, exp_m);
        check({tag, "_stat_u"}, stat_unsolved, exp_u);
`endif
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check({tag, "_hold_valid"}, total_valid, 1);
            check({tag, "_hold_total"}, total_presses, exp_total);
        end
        tick();
        total_ack = 1'b1;
        tick();
        total_ack = 1'b0;
        @(negedge clk);
        check({tag, "_ack_valid"}, total_valid, 0);
        check({tag, "_ack_total"}, total_presses, exp_total);
    endtask

    // Reference: the total is the plain sum of answers, clamped at 2^SW-1.
    task automatic run_set(input string tag, input int hold);
        int st, sum, tens, n;
        sum = 0;
        tens = 0;
        n = run_ans.size();
        stall_q.delete();
        for (int i = 0; i < n; i++) begin
            send(run_ans[i], run_lat[i], (i == n - 1), st);
            stall_q.push_back(st);
            sum += run_ans[i];
            if (run_ans[i] == BC) tens++;
        end
        finish_run(tag, (sum > SMAX) ? SMAX : sum, (sum > SMAX) ? 1 : 0,
                   (n > SMAX) ? SMAX : n, (tens > SMAX) ? SMAX : tens, hold);
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge clk);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_total_valid"}, total_valid, 0);
        check({tag, "_total"}, total_presses, 0);
        check({tag, "_ovf"}, total_overflow, 0);
        check({tag, "_tx"}, core_tx_valid, 0);
        check({tag, "_rx"}, core_rx_ready, 0);
`ifdef COMBO_DISPATCH_STATS_EN
        check({tag, "_stat_m"}, stat_machines, 0);
        check({tag, "_stat_u"}, stat_unsolved, 0);
`endif
    endtask

    initial begin
        int st, exp_order [5];
        exp_order = '{0, 1, 0, 1, 0};

        do_reset();
        check_reset_outputs("rst");

        // Two cores finishing together are collected on consecutive cycles.
        coll_core_q.delete();
        coll_cyc_q.delete();
        run_ans = '{4, 5};
        run_lat = '{5, 4};
        run_set("simul", 0);
        check("simul_ncoll", coll_core_q.size(), 2);
        if (coll_core_q.size() == 2) begin
            check("simul_first", coll_core_q[0], 0);
            check("simul_second", coll_core_q[1], 1);
            check("simul_gap", coll_cyc_q[1] - coll_cyc_q[0], 1);
        end

        run_ans = '{2, 3, 2};
        run_lat = '{3, 1, 6};
        run_set("three", 3);

        // Only two cores available: in_ready stalls and dispatch alternates.
        en_m = 4'b0011;
        do_reset();
        disp_q.delete();
        run_ans = '{1, 2, 3, 1, 2};
        run_lat = '{6, 6, 6, 6, 6};
        run_set("two_core", 1);
        check("two_core_stall", (stall_q[2] > 0), 1);
        check("two_core_ndisp", disp_q.size(), 5);
        for (int i = 0; i < 5 && i < disp_q.size(); i++) begin
            check("two_core_order", disp_q[i], exp_order[i]);
        end
        en_m = '1;

        run_ans = '{10, 8};
        run_lat = '{2, 3};
        run_set("sat", 1);

        run_ans = '{10, 1, 2, 1};
        run_lat = '{1, 4, 2, 3};
        run_set("stats", 0);

        // Reset in DRAIN with two results still outstanding.
        send(3, 2, 0, st);
        send(7, 40, 0, st);
        send(7, 40, 1, st);
        repeat (5) tick();
        @(negedge clk);
        check("pre_rst_partial", total_presses, 3);
        tick();
        reset = 1'b1;
        tick();
        check_reset_outputs("mid_rst");
        reset = 1'b0;
        coll_core_q.delete();
        run_ans = '{1, 2};
        run_lat = '{50, 50};
        run_set("post_rst", 0);
        check("post_rst_stale_drained", coll_core_q.size(), 4);

        for (int r = 0; r < 15; r++) begin
            int n;
            n = $urandom_range(1, 5);
            run_ans.delete();
            run_lat.delete();
            for (int i = 0; i < n; i++) begin
                run_ans.push_back($urandom_range(0, BC));
                run_lat.push_back($urandom_range(1, 8));
            end
            run_set("rand", $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/combo_solver_dispatcher.md
COMBO_SOLVER_DISPATCHER -- requirements
Module: combo_solver_dispatcher

Interface
REQ-001 Parameter NUM_CORES, default 4: number of combo solver cores scheduled by this block.
REQ-002 Parameter MAX_LIGHT_COUNT, default 2: lights per machine; MAX_BUTTON_COUNT, default 10: buttons per machine.
REQ-003 Parameter SUM_WIDTH, default 16: width of the accumulated press total.
REQ-004 Clock and reset SHALL be one clock and a synchronous, active-high reset:
- clk  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
REQ-005 Upstream input ports:
- in_valid  in  1  machine descriptor valid.
- in_buttons  in  MAX_LIGHT_COUNT*MAX_BUTTON_COUNT  flattened button masks, button i at bits [i*MAX_LIGHT_COUNT +: MAX_LIGHT_COUNT].
- in_lights  in  MAX_LIGHT_COUNT  expected light pattern.
- in_last  in  1  final machine of the puzzle.
- in_ready  out  1  descriptor accepted when in_valid && in_ready.
REQ-006 Core-side ports:
- core_buttons  out  same width as in_buttons  broadcast copy of in_buttons.
- core_lights  out  MAX_LIGHT_COUNT  broadcast copy of in_lights.
- core_tx_valid  out  NUM_CORES  one-hot dispatch strobe.
- core_ready  in  NUM_CORES  core idle.
- core_presses  in  NUM_CORES*$clog2(MAX_BUTTON_COUNT+1)  flattened per-core results.
- core_presses_valid  in  NUM_CORES  per-core result valid.
- core_rx_ready  out  NUM_CORES  one-hot result collect strobe.
REQ-007 Result ports:
- total_presses  out  SUM_WIDTH  accumulated minimum presses.
- total_overflow  out  1  total saturated.
- total_valid  out  1  total is final.
- total_ack  in  1  consumer takes the total.

Function
REQ-008 The FSM SHALL have 4 states: IDLE, RUN, DRAIN, DONE.
- IDLE: on in_valid, go to RUN with the accumulator cleared; that same cycle is not an accept.
- RUN: after accepting a descriptor with in_last=1, go to DRAIN.
- DRAIN: when outstanding==0 and no collect is occurring this cycle, go to DONE.
- DONE: on total_ack, go to IDLE.
REQ-009 A core is free iff core_ready[i] && !core_presses_valid[i] && !busy[i]. busy[i] is set on dispatch and cleared on collect.
REQ-010 in_ready SHALL be 1 only in RUN when at least one core is free; it is combinational from registered state and core inputs.
REQ-011 On accept, core_tx_valid SHALL strobe the free core chosen by a round-robin pointer, starting after the last dispatched core. The strobe is 1 cycle, combinational with the accept; the pointer updates at the edge.
REQ-012 Collect: each cycle, one core with core_presses_valid=1 SHALL be selected by an independent round-robin pointer. core_rx_ready for that core SHALL strobe combinationally the same cycle, and its result is added at the edge.
REQ-013 Dispatch and collect in the same cycle SHALL both proceed. They are always to different cores (REQ-009). The outstanding counter is then unchanged.
REQ-014 Outstanding counter width is $clog2(NUM_CORES+1). It increments on dispatch and decrements on collect, and never underflows; a collect with busy[i]=0 is ignored and not summed.
REQ-015 The accumulator SHALL zero-extend each result and saturate at 2^SUM_WIDTH-1. total_overflow is sticky until the next IDLE->RUN.
REQ-016 total_valid SHALL be 1 exactly in DONE. total_presses holds its value until the next IDLE->RUN.
REQ-017 in_valid with in_last=1 SHALL be accepted like any other descriptor. A run with zero descriptors is impossible by REQ-008.

Reset
REQ-018 Reset SHALL set the following; reset mid-run abandons all work with no partial total reported:
- state=IDLE
- both pointers=0
- busy=0
- outstanding=0
- total_presses=0
- total_overflow=0
- total_valid=0
- core_tx_valid=0
- core_rx_ready=0
- in_ready=0

Configuration
REQ-019 Macro COMBO_DISPATCH_STATS_EN, when defined, SHALL add outputs stat_machines (SUM_WIDTH, count of collected results) and stat_unsolved (SUM_WIDTH, collected results equal to MAX_BUTTON_COUNT). Both clear on reset and on IDLE->RUN, and saturate.
REQ-020 Without COMBO_DISPATCH_STATS_EN, those ports and counters SHALL be absent and all other behaviour is identical.

Structure
REQ-021 A shared package SHALL hold the FSM state encodings and the presses width function $clog2(MAX_BUTTON_COUNT+1).
REQ-022 One sub-module, rr_arbiter (parameter N; inputs req, advance; output one-hot grant), SHALL be instantiated twice: once for dispatch and once for collect.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Three machines with answers 2, 3, 2, NUM_CORES=4 -> total_presses=7, total_valid in DONE, held until total_ack.
- NUM_CORES=2, five back-to-back machines -> in_ready drops while both cores are busy; dispatch order is cores 0,1,0,1,0; total is correct.
- Two cores finish in the same cycle -> collected on consecutive cycles in round-robin order; each is summed once.
- SUM_WIDTH=4 and results summing to 18 -> total_presses=15, total_overflow=1.
- Reset asserted in DRAIN with 2 outstanding -> all outputs reach reset values next cycle; the following run's total excludes stale results.
- With COMBO_DISPATCH_STATS_EN, 4 machines with one result equal to 10 -> stat_machines=4, stat_unsolved=1.
